mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from the shared package (DATA_WIDTH=32, DataPath, DataAddrPath).
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-low (0 = reset, sampled on posedge clk).
REQ-004 req  input  1  core access request, sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  MemAccessSize (2)  BYTE/HALF/WORD.
REQ-007 signExt  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  input  DataAddrPath  byte address.
REQ-009 wdata  input  DataPath  store data, right-aligned.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse, registered.
REQ-012 rdata  output  DataPath  load result, registered, valid while done=1 and held until next load.
REQ-013 misalign  output  1  error pulse coincident with done (MEM_ACCESS_MISALIGN_CHECK_EN only; else tied 0).
REQ-014 dmemAddr / dmemDataIn / dmemWrEnable  output  DataAddrPath/DataPath/1  drive the data memory, which registers them at posedge.
REQ-015 dmemDataOut  input  DataPath  memory word, valid the cycle after its address was registered.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE; req SHALL be accepted only in IDLE, ignored otherwise.
REQ-017 On acceptance, addr (word-aligned), byte offset, size, signExt and wdata SHALL be captured into internal registers.
REQ-018 In IDLE, dmemAddr SHALL equal addr with bits [1:0] cleared; dmemWrEnable SHALL be 1 only for an accepted, aligned WORD store, with dmemDataIn=wdata.
REQ-019 Word store: IDLE->IDLE; done=1 the cycle after acceptance (latency 1).
REQ-020 Load: IDLE->LOAD_WAIT->IDLE; in LOAD_WAIT the selected lane of dmemDataOut SHALL be extended and registered into rdata; done=1 the cycle after LOAD_WAIT (latency 2).
REQ-021 Byte/half store: IDLE (read issued, we=0)->RMW_READ (merge wdata lane into dmemDataOut, register merged word)->RMW_WRITE (drive captured address, merged word, dmemWrEnable=1)->IDLE; done=1 the cycle after RMW_WRITE (latency 3).
REQ-022 Lanes SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1]; unselected bytes SHALL be preserved bit-exact on sub-word stores.
REQ-023 In LOAD_WAIT and RMW_READ, dmemAddr SHALL hold the captured address and dmemWrEnable SHALL be 0.
REQ-024 Back-to-back requests SHALL be correct: a load or RMW to the address of a store that completed the previous cycle SHALL observe the stored data.
REQ-025 done SHALL never be asserted for two consecutive cycles for one request; busy and done SHALL not be high in the same cycle except when a new request is accepted in the done cycle.

Reset
REQ-026 While rst=0: state=IDLE, busy=0, done=0, misalign=0, rdata=0, dmemWrEnable=0, all captured registers=0.
REQ-027 Reset asserted mid-operation (any state) SHALL abort the access with no write issued on the following cycle and no done pulse.

Configuration
REQ-028 With MEM_ACCESS_MISALIGN_CHECK_EN defined: WORD with addr[1:0]!=0 or HALF with addr[0]!=0 SHALL issue no memory write, return to IDLE, and pulse done=1, misalign=1, rdata=0 one cycle after acceptance.
REQ-029 Without MEM_ACCESS_MISALIGN_CHECK_EN: misalign SHALL be tied 0; WORD ignores addr[1:0], HALF ignores addr[0].

Structure
REQ-030 MemAccessSize enum (BYTE=0, HALF=1, WORD=2) and the FSM state enum SHALL be in the shared Types package.
REQ-031 Lane extraction/extension and store merge SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-032 Memory word 0x40 = 0x11223344; load BYTE addr 0x42 signExt=0 -> rdata=0x00000022, done at cycle 2.
REQ-033 Word 0x80 = 0x000080FF; load HALF addr 0x80 signExt=1 -> rdata=0xFFFF80FF; load BYTE addr 0x81 signExt=1 -> 0xFFFFFF80.
REQ-034 Word 0x40 = 0x11223344; store BYTE 0xAA to 0x41 -> done at cycle 3, word reads 0x1122AA44.
REQ-035 Store WORD 0xDEADBEEF to 0x10, then load WORD 0x10 in the next cycle -> rdata=0xDEADBEEF.
REQ-036 Store HALF to 0x42, rst=0 during RMW_READ -> no write, word 0x40 unchanged, done never asserted.
REQ-037 With MEM_ACCESS_MISALIGN_CHECK_EN: store WORD to 0x13 -> misalign=1 and done=1 at cycle 1, memory unchanged; without it -> word 0x10 written.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared types for the memory access unit: data/address widths, the access
// size encoding and the controller state encoding. Also provides the
// alignment rule used by the optional misalignment check
// (MEM_ACCESS_MISALIGN_CHECK_EN).
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 32;

   typedef logic [DATA_WIDTH-1:0] DataPath;
   typedef logic [ADDR_WIDTH-1:0] DataAddrPath;

   typedef enum logic [1:0] {
      SizeByte = 2'd0,
      SizeHalf = 2'd1,
      SizeWord = 2'd2
   } MemAccessSize;

   typedef enum logic [1:0] {
      StIdle,
      StLoadWait,
      StRmwRead,
      StRmwWrite
   } mau_state_e;

   // A WORD needs a 4-byte aligned address, a HALF a 2-byte aligned one.
   function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
      return ((size == SizeWord) && (off != 2'b00)) ||
             ((size == SizeHalf) && off[0]);
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational little-endian lane handling for the memory access unit.
//   word_i  : word read from data memory
//   wdata_i : right-aligned store data
//   size_i  : access size (MemAccessSize encoding)
//   off_i   : byte offset within the word (addr[1:0])
//   sext_i  : 1 = sign-extend loads, 0 = zero-extend
//   load_o  : selected lane of word_i, extended to a full word
//   merge_o : word_i with the selected lane replaced by wdata_i's low bytes
// Byte lane = off_i, half lane = off_i[1]; a WORD ignores off_i entirely.
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [1:0]            size_i,
   input  logic [1:0]            off_i,
   input  logic                  sext_i,
   output logic [DATA_WIDTH-1:0] load_o,
   output logic [DATA_WIDTH-1:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[8*off_i +: 8];
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
      load_o   = word_i;
      merge_o  = wdata_i;
      case (size_i)
         SizeByte: begin
            load_o  = {{(DATA_WIDTH-8){sext_i & byte_sel[7]}}, byte_sel};
            merge_o = word_i;
            merge_o[8*off_i +: 8] = wdata_i[7:0];
         end
         SizeHalf: begin
            load_o  = {{(DATA_WIDTH-16){sext_i & half_sel[15]}}, half_sel};
            merge_o = word_i;
            if (off_i[1]) begin
               merge_o[31:16] = wdata_i[15:0];
            end else begin
               merge_o[15:0] = wdata_i[15:0];
            end
         end
         default: begin
            load_o  = word_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Byte/half/word load-store unit in front of a synchronous data memory that
// registers its address at posedge and returns the word the following cycle.
//   clk, rst (sync, active-low) ; req/we/size/signExt/addr/wdata : core request
//   busy     : high whenever the controller is not idle
//   done     : registered one-cycle completion pulse
//   rdata    : registered load result, held until the next load
//   misalign : error pulse with done (only with MEM_ACCESS_MISALIGN_CHECK_EN)
//   dmemAddr/dmemDataIn/dmemWrEnable/dmemDataOut : data memory port
// Latencies (acceptance to done): word store 1, load 2, sub-word store 3
// (read-modify-write).
// Optional feature macro: MEM_ACCESS_MISALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic                  signExt,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  misalign,
   output logic [ADDR_WIDTH-1:0] dmemAddr,
   output logic [DATA_WIDTH-1:0] dmemDataIn,
   output logic                  dmemWrEnable,
   input  logic [DATA_WIDTH-1:0] dmemDataOut
);

   mau_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            off_q, off_d;
   logic [1:0]            size_q, size_d;
   logic                  sext_q, sext_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] merged_q, merged_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  done_q, done_d;
   logic                  bad_access;
   logic [DATA_WIDTH-1:0] lane_load;
   logic [DATA_WIDTH-1:0] lane_merge;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   assign bad_access = is_misaligned(size, addr[1:0]);
   assign misalign   = misalign_q;
`else
   assign bad_access = 1'b0;
   assign misalign   = 1'b0;
`endif

   mem_lane_align u_lane_align (
      .word_i  (dmemDataOut),
      .wdata_i (wdata_q),
      .size_i  (size_q),
      .off_i   (off_q),
      .sext_i  (sext_q),
      .load_o  (lane_load),
      .merge_o (lane_merge)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      off_d        = off_q;
      size_d       = size_q;
      sext_d       = sext_q;
      wdata_d      = wdata_q;
      merged_d     = merged_q;
      rdata_d      = rdata_q;
      done_d       = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      misalign_d   = 1'b0;
`endif
      dmemAddr     = {addr[ADDR_WIDTH-1:2], 2'b00};
      dmemDataIn   = wdata;
      dmemWrEnable = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
               off_d   = addr[1:0];
               size_d  = size;
               sext_d  = signExt;
               wdata_d = wdata;
               if (bad_access) begin
                  done_d  = 1'b1;
                  rdata_d = '0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
                  misalign_d = 1'b1;
`endif
               end else if (we && (size == SizeWord)) begin
                  dmemWrEnable = 1'b1;
                  done_d       = 1'b1;
               end else if (we) begin
                  // Sub-word store: the read issued here feeds the merge.
                  state_d = StRmwRead;
               end else begin
                  state_d = StLoadWait;
               end
            end
         end
         StLoadWait: begin
            dmemAddr = addr_q;
            rdata_d  = lane_load;
            done_d   = 1'b1;
            state_d  = StIdle;
         end
         StRmwRead: begin
            dmemAddr = addr_q;
            merged_d = lane_merge;
            state_d  = StRmwWrite;
         end
         StRmwWrite: begin
            dmemAddr     = addr_q;
            dmemDataIn   = merged_q;
            dmemWrEnable = 1'b1;
            done_d       = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Reset aborts whatever is in flight, including a pending write.
      if (!rst) begin
         dmemWrEnable = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         off_q      <= '0;
         size_q     <= '0;
         sext_q     <= 1'b0;
         wdata_q    <= '0;
         merged_q   <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         off_q      <= off_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         wdata_q    <= wdata_d;
         merged_q   <= merged_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign busy  = (state_q != StIdle);
   assign done  = done_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench: a synchronous data memory, a byte-array reference
// model, a directed vector table, hand-written corner sequences (back-to-back,
// reset abort, misalignment) and randomized aligned accesses.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'd0;
   logic        signExt = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        busy, done, misalign, dmemWrEnable;
   logic [31:0] rdata, dmemAddr, dmemDataIn, dmemDataOut;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .we           (we),
      .size         (size),
      .signExt      (signExt),
      .addr         (addr),
      .wdata        (wdata),
      .busy         (busy),
      .done         (done),
      .rdata        (rdata),
      .misalign     (misalign),
      .dmemAddr     (dmemAddr),
      .dmemDataIn   (dmemDataIn),
      .dmemWrEnable (dmemWrEnable),
      .dmemDataOut  (dmemDataOut)
   );

   // Data memory: address registered at posedge, word returned next cycle.
   logic [31:0] mem [0:255];
   logic [7:0]  ra = '0;
   logic        bd_we = 1'b0;
   logic [7:0]  bd_idx = '0;
   logic [31:0] bd_data = '0;

   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (dmemWrEnable) mem[dmemAddr[9:2]] <= dmemDataIn;
      ra <= dmemAddr[9:2];
   end
   assign dmemDataOut = mem[ra];

   // Reference model: plain byte-addressed memory.
   logic [7:0] refb [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input int sz, input bit sx, input int a);
      int     n = 1 << sz;
      int     base = a - (a % n);
      longint v = 0;
      for (int i = 0; i < n; i++) v += longint'(refb[base+i]) << (8*i);
      if (sx && n < 4 && refb[base+n-1][7]) v -= longint'(1) << (8*n);
      return v[31:0];
   endfunction

   function automatic void ref_store(input int sz, input int a, input logic [31:0] d);
      int n = 1 << sz;
      int base = a - (a % n);
      for (int i = 0; i < n; i++) refb[base+i] = d[8*i +: 8];
   endfunction

   function automatic logic [31:0] ref_word(input int a);
      int b = a - (a % 4);
      return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
   endfunction

   task automatic bd_write(input int idx, input logic [31:0] d);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_idx  = 8'(idx);
      bd_data = d;
      @(posedge clk);
      #1 bd_we = 1'b0;
      for (int i = 0; i < 4; i++) refb[idx*4+i] = d[8*i +: 8];
   endtask

   // Counts cycles from acceptance to done; done must drop the cycle after.
   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      check("done_seen", 32'(done), 32'd1);
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
   endtask

   task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic mis);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; signExt = sx; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      rd  = rdata;
      mis = misalign;
      check("done_seen", 32'(done), 32'd1);
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        sx;
      logic [31:0] a;
      logic [31:0] d;
      int          lat;
      logic [31:0] exp;   // rdata for loads, memory word for stores
   } vec_t;

   vec_t tbl [14];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic [31:0] exp;
      logic        mis;

      tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h42, 32'h0,        2, 32'h00000022};
      tbl[1]  = '{1'b0, 2'd1, 1'b1, 32'h80, 32'h0,        2, 32'hFFFF80FF};
      tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h81, 32'h0,        2, 32'hFFFFFF80};
      tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        2, 32'h11223344};
      tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h41, 32'hAA,       3, 32'h1122AA44};
      tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h42, 32'h5566,     3, 32'h5566AA44};
      tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h42, 32'h0,        2, 32'h00005566};
      tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h43, 32'h0,        2, 32'h00000055};
      tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h43, 32'hFFFFFF77, 3, 32'h7766AA44};
      tbl[9]  = '{1'b0, 2'd0, 1'b1, 32'h43, 32'h0,        2, 32'h00000077};
      tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h80, 32'h0,        2, 32'h000080FF};
      tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h44, 32'hCAFEF00D, 1, 32'hCAFEF00D};
      tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        2, 32'h7766AA44};
      tbl[13] = '{1'b0, 2'd0, 1'b1, 32'h40, 32'h0,        2, 32'h00000044};

      // Reset state
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_wren", 32'(dmemWrEnable), 32'd0);

      for (int i = 0; i < 64; i++) bd_write(i, $urandom);
      bd_write(32'h40 / 4, 32'h11223344);
      bd_write(32'h80 / 4, 32'h000080FF);
      @(negedge clk);
      rst = 1'b1;

      // Directed vectors
      for (int i = 0; i < 14; i++) begin
         access(tbl[i].w, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d, lat, rd, mis);
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         check($sformatf("tbl%0d_misalign", i), 32'(mis), 32'd0);
         if (tbl[i].w) begin
            ref_store(int'(tbl[i].sz), int'(tbl[i].a), tbl[i].d);
            check($sformatf("tbl%0d_memword", i), mem[tbl[i].a[9:2]], tbl[i].exp);
         end else begin
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
         end
      end

      // Word store followed by a load accepted in the store's done cycle
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'd2; signExt = 1'b0; addr = 32'h10; wdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      check("b2b_store_done", 32'(done), 32'd1);
      check("b2b_store_busy", 32'(busy), 32'd0);
      we = 1'b0;
      @(posedge clk);
      #1 req = 1'b0;
      wait_done(lat);
      check("b2b_load_latency", 32'(lat), 32'd2);
      check("b2b_load_rdata", rdata, 32'hDEADBEEF);
      ref_store(2, 32'h10, 32'hDEADBEEF);

      // Reset asserted while a half store sits in RMW_READ
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'd1; addr = 32'h42; wdata = 32'h9999;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      check("rmw_read_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_wren", 32'(dmemWrEnable), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_rdata", rdata, 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("abort_no_done_%0d", i), 32'(done), 32'd0);
         check($sformatf("abort_no_write_%0d", i), 32'(dmemWrEnable), 32'd0);
      end
      check("abort_memword", mem[32'h40 / 4], ref_word(32'h40));

      // Misaligned word store
      access(1'b1, 2'd2, 1'b0, 32'h13, 32'h12345678, lat, rd, mis);
      check("mis_store_latency", 32'(lat), 32'd1);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      check("mis_store_flag", 32'(mis), 32'd1);
      check("mis_store_rdata", rd, 32'd0);
      check("mis_store_memword", mem[32'h10 / 4], ref_word(32'h10));
      access(1'b0, 2'd1, 1'b1, 32'h41, 32'h0, lat, rd, mis);
      check("mis_load_latency", 32'(lat), 32'd1);
      check("mis_load_flag", 32'(mis), 32'd1);
      check("mis_load_rdata", rd, 32'd0);
`else
      check("mis_store_flag", 32'(mis), 32'd0);
      ref_store(2, 32'h13, 32'h12345678);
      check("mis_store_memword", mem[32'h10 / 4], ref_word(32'h10));
`endif

      // Randomized aligned accesses against the reference model
      for (int i = 0; i < 300; i++) begin
         logic        w, sx;
         logic [1:0]  sz;
         logic [31:0] a, d;
         w  = 1'($urandom_range(0, 1));
         sx = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 255));
         if (sz == 2'd2) a[1:0] = 2'b00;
         if (sz == 2'd1) a[0] = 1'b0;
         d  = $urandom;
         exp = ref_load(int'(sz), sx, int'(a));
         access(w, sz, sx, a, d, lat, rd, mis);
         check($sformatf("rnd%0d_latency", i), 32'(lat),
               w ? ((sz == 2'd2) ? 32'd1 : 32'd3) : 32'd2);
         check($sformatf("rnd%0d_misalign", i), 32'(mis), 32'd0);
         if (w) begin
            ref_store(int'(sz), int'(a), d);
            check($sformatf("rnd%0d_memword", i), mem[a[9:2]], ref_word(int'(a)));
         end else begin
            check($sformatf("rnd%0d_rdata", i), rd, exp);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
